rvb_pcpi_bridge: RTL and testbench

Initiator-side adapter that takes PicoRV32-style PCPI co-processor requests and drives the din/dout valid/ready interface of a bit-manip execution unit such as rvb_bextdep. It decodes bext/bdep/grev (and the RV64 W-forms), then issues exactly one din transaction. It drains exactly one dout result and returns it as a single-cycle pcpi_ready/pcpi_wr pulse. The bridge sits between the CPU core and the unit, and owns all flow control across that boundary.

---
 rtl/rvb_pcpi_bridge.sv | 144 ++++++++++++++
 tb/tb_rvb_pcpi_bridge.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvb_pcpi_bridge.sv
// PCPI co-processor front end for a bit-manip unit with din/dout valid/ready ports.
// Decodes bext/bdep/grev (plus RV64 W-forms), issues one request, returns one result.
module rvb_pcpi_bridge #(
    parameter int XLEN = 32,
    parameter bit GREV = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            pcpi_valid,
    input  logic [31:0]     pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1,
    input  logic [XLEN-1:0] pcpi_rs2,
    output logic            pcpi_wr,
    output logic [XLEN-1:0] pcpi_rd,
    output logic            pcpi_wait,
    output logic            pcpi_ready,
    output logic            din_valid,
    input  logic            din_ready,
    output logic [XLEN-1:0] din_rs1,
    output logic [XLEN-1:0] din_rs2,
    output logic            din_insn3,
    output logic            din_insn13,
    output logic            din_insn14,
    output logic            din_insn30,
    input  logic            dout_valid,
    output logic            dout_ready,
    input  logic [XLEN-1:0] dout_rd
);

    localparam int          NUM_OPS   = 3;
    localparam logic [31:0] DEC_MASK  = 32'hFE00707F;
    localparam logic [31:0] W_OPC_BIT = 32'h00000008;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, HOLD, DRAIN} state_t;

    function automatic logic [31:0] op_pattern(input int idx);
        return (idx == 0) ? 32'h08006033 :
               (idx == 1) ? 32'h48006033 : 32'h68005033;
    endfunction

    state_t          state_reg, state_next;
    logic [XLEN-1:0] rs1_reg, rs2_reg, rd_reg;
    logic            insn3_reg, insn13_reg, insn14_reg, insn30_reg;
    logic [31:0]     insn_masked;
    logic [2*NUM_OPS-1:0] pat_hit;
    logic            insn_match;
    logic            accept;
    logic            capture;

    // Entries 0..2 are the base opcodes, 3..5 the same ops with the 0x3B W-form opcode.
    assign insn_masked = pcpi_insn & DEC_MASK;

    for (genvar gi = 0; gi < 2 * NUM_OPS; gi++) begin : g_decode
        localparam bit          IS_WFORM = (gi >= NUM_OPS);
        localparam bit          ENABLED  = (((gi % NUM_OPS) != 2) || GREV) &&
                                           (!IS_WFORM || (XLEN == 64));
        localparam logic [31:0] PATTERN  = op_pattern(gi % NUM_OPS) |
                                           (IS_WFORM ? W_OPC_BIT : 32'h0);
        if (ENABLED) begin : g_on
            assign pat_hit[gi] = (insn_masked == PATTERN);
        end else begin : g_off
            assign pat_hit[gi] = 1'b0;
        end
    end

    assign insn_match = |pat_hit;
    assign accept     = (state_reg == IDLE) && pcpi_valid && insn_match;
    // A result that lands in the same cycle the core gives up is consumed but not returned.
    assign capture    = (state_reg == WAIT) && dout_valid && pcpi_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            rs1_reg    <= '0;
            rs2_reg    <= '0;
            rd_reg     <= '0;
            insn3_reg  <= 1'b0;
            insn13_reg <= 1'b0;
            insn14_reg <= 1'b0;
            insn30_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                rs1_reg    <= pcpi_rs1;
                rs2_reg    <= pcpi_rs2;
                insn3_reg  <= pcpi_insn[3] & (XLEN == 64);
                insn13_reg <= pcpi_insn[13];
                insn14_reg <= pcpi_insn[14];
                insn30_reg <= pcpi_insn[30];
            end
            if (capture) begin
                rd_reg <= dout_rd;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        pcpi_wait  = 1'b0;
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = ISSUE;
            end
            ISSUE: begin
                din_valid = 1'b1;
                pcpi_wait = 1'b1;
                if (din_ready) state_next = pcpi_valid ? WAIT : DRAIN;
            end
            WAIT: begin
                dout_ready = 1'b1;
                pcpi_wait  = 1'b1;
                if (dout_valid)       state_next = pcpi_valid ? RESP : IDLE;
                else if (!pcpi_valid) state_next = DRAIN;
            end
            RESP: begin
                pcpi_ready = 1'b1;
                pcpi_wr    = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                // Core still shows the finished request; wait for it to let go.
                if (!pcpi_valid) state_next = IDLE;
            end
            DRAIN: begin
                dout_ready = 1'b1;
                if (dout_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign din_rs1    = rs1_reg;
    assign din_rs2    = rs2_reg;
    assign din_insn3  = insn3_reg;
    assign din_insn13 = insn13_reg;
    assign din_insn14 = insn14_reg;
    assign din_insn30 = insn30_reg;
    assign pcpi_rd    = rd_reg;

endmodule

// File: tb/tb_rvb_pcpi_bridge.sv
// Bench for rvb_pcpi_bridge: an RV64 instance with a stalling unit model, plus an RV32 bext/bdep-only instance.
`timescale 1ns/1ps
module tb_rvb_pcpi_bridge;

    localparam logic [31:0] MASK  = 32'hFE00707F;
    localparam logic [31:0] BEXT  = 32'h08006033;
    localparam logic [31:0] BDEP  = 32'h48006033;
    localparam logic [31:0] GREVP = 32'h68005033;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // 64-bit instance
    logic        pcpi_valid, pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_insn;
    logic [63:0] pcpi_rs1, pcpi_rs2, pcpi_rd;
    logic        din_valid, din_ready, din_insn3, din_insn13, din_insn14, din_insn30;
    logic [63:0] din_rs1, din_rs2;
    logic        dout_valid, dout_ready;
    logic [63:0] dout_rd;

    // 32-bit instance, GREV disabled, unit always ready with zero latency
    logic        valid_s, wr_s, wait_s, ready_s;
    logic [31:0] insn_s, rs1_s, rs2_s, rd_s;
    logic        din_valid_s, din_ready_s, din_insn3_s, din_insn13_s, din_insn14_s, din_insn30_s;
    logic [31:0] din_rs1_s, din_rs2_s;
    logic        dout_valid_s, dout_ready_s;
    logic [31:0] dout_rd_s;

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int cyc = 0, hold_low_until = 0, n_issued = 0;
    int req_cnt = 0, resp_cnt = 0, u_lat = 0;
    bit stall_mode = 1'b0;
    logic u_busy;
    logic [63:0] cap_rs1, cap_rs2;
    logic [3:0]  cap_bits;

    rvb_pcpi_bridge #(.XLEN(64), .GREV(1'b1)) u_dut (
        .clock(clock), .reset(reset),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
        .din_valid(din_valid), .din_ready(din_ready), .din_rs1(din_rs1), .din_rs2(din_rs2),
        .din_insn3(din_insn3), .din_insn13(din_insn13), .din_insn14(din_insn14), .din_insn30(din_insn30),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_rd(dout_rd)
    );

    rvb_pcpi_bridge #(.XLEN(32), .GREV(1'b0)) u_dut32 (
        .clock(clock), .reset(reset),
        .pcpi_valid(valid_s), .pcpi_insn(insn_s), .pcpi_rs1(rs1_s), .pcpi_rs2(rs2_s),
        .pcpi_wr(wr_s), .pcpi_rd(rd_s), .pcpi_wait(wait_s), .pcpi_ready(ready_s),
        .din_valid(din_valid_s), .din_ready(din_ready_s), .din_rs1(din_rs1_s), .din_rs2(din_rs2_s),
        .din_insn3(din_insn3_s), .din_insn13(din_insn13_s), .din_insn14(din_insn14_s), .din_insn30(din_insn30_s),
        .dout_valid(dout_valid_s), .dout_ready(dout_ready_s), .dout_rd(dout_rd_s)
    );

    // Bit-manip semantics: 0 = bext (gather), 1 = bdep (scatter), 2 = grev; w = 32-bit op, sign-extended.
    function automatic logic [63:0] ref_op(input int op, input bit w, input logic [63:0] a, input logic [63:0] b);
        int width, j, k;
        logic [63:0] r;
        width = w ? 32 : 64;
        j = 0;
        r = '0;
        k = int'(b[5:0]) & (width - 1);
        for (int i = 0; i < width; i++) begin
            if (op == 0) begin
                if (b[i]) begin r[j] = a[i]; j++; end
            end else if (op == 1) begin
                if (b[i]) begin r[i] = a[j]; j++; end
            end else begin
                r[i ^ k] = a[i];
            end
        end
        if (w) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    function automatic int insn_op(input logic [31:0] insn);
        return (insn[14:12] == 3'b101) ? 2 : (insn[30] ? 1 : 0);
    endfunction

    function automatic bit insn_w(input logic [31:0] insn);
        return insn[6:0] == 7'h3B;
    endfunction

    function automatic bit dec64(input logic [31:0] insn);
        logic [31:0] m;
        m = insn & MASK;
        return (m == BEXT) || (m == BDEP) || (m == GREVP) ||
               (m == (BEXT | 32'h8)) || (m == (BDEP | 32'h8)) || (m == (GREVP | 32'h8));
    endfunction

    function automatic int unit_op(input logic i13, input logic i30);
        return !i13 ? 2 : (i30 ? 1 : 0);
    endfunction

    function automatic logic [31:0] calc32(input logic i13, input logic i30, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] t;
        t = ref_op(unit_op(i13, i30), 1'b1, {32'h0, a}, {32'h0, b});
        return t[31:0];
    endfunction

    assign din_ready_s  = 1'b1;
    assign dout_valid_s = 1'b1;
    assign dout_rd_s    = calc32(din_insn13_s, din_insn30_s, din_rs1_s, din_rs2_s);

    always @(posedge clock) cyc <= cyc + 1;

    // Execution unit model for the 64-bit instance: computes from what it receives on din.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            din_ready  <= 1'b0;
            dout_valid <= 1'b0;
            dout_rd    <= '0;
            u_busy     <= 1'b0;
            u_lat      <= 0;
        end else begin
            din_ready <= (cyc < hold_low_until) ? 1'b0 :
                         (stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (din_valid && din_ready) begin
                u_busy   <= 1'b1;
                u_lat    <= stall_mode ? int'($urandom_range(0, 4)) : 0;
                dout_rd  <= ref_op(unit_op(din_insn13, din_insn30), din_insn3, din_rs1, din_rs2);
                cap_rs1  <= din_rs1;
                cap_rs2  <= din_rs2;
                cap_bits <= {din_insn3, din_insn13, din_insn14, din_insn30};
                req_cnt  <= req_cnt + 1;
            end else if (u_busy && !dout_valid) begin
                if (u_lat == 0) dout_valid <= 1'b1;
                else            u_lat <= u_lat - 1;
            end
            if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
                u_busy     <= 1'b0;
                resp_cnt   <= resp_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request at posedge+1 with the bridge idle; pcpi_wait must be up one edge later.
    task automatic begin_req(input logic [31:0] insn, input logic [63:0] a, input logic [63:0] b);
        pcpi_insn  = insn;
        pcpi_rs1   = a;
        pcpi_rs2   = b;
        pcpi_valid = 1'b1;
        @(posedge clock); #1;
        chk("wait_t1", pcpi_wait, dec64(insn));
    endtask

    // Follow a matching request to completion; abort_at >= 0 drops pcpi_valid after that many cycles.
    task automatic end_req(input logic [31:0] insn, input logic [63:0] a, input logic [63:0] b, input int abort_at);
        logic [63:0] exp_rd;
        int n_rdy, n;
        bit aborted, done;
        exp_rd  = ref_op(insn_op(insn), insn_w(insn), a, b);
        n_rdy   = 0;
        n       = 0;
        aborted = 1'b0;
        done    = 1'b0;
        n_issued++;
        while (!done && n < 300) begin
            if (!aborted && n_rdy == 0 && n == abort_at) begin
                pcpi_valid = 1'b0;
                aborted    = 1'b1;
            end
            @(posedge clock); #1;
            n++;
            if (pcpi_ready) begin
                n_rdy++;
                chk("rd", pcpi_rd, exp_rd);
                chk("wr", pcpi_wr, 1'b1);
                chk("wait_in_resp", pcpi_wait, 1'b0);
                pcpi_valid = 1'b0;
            end else if (!aborted && n_rdy == 0) begin
                chk("wait_busy", pcpi_wait, 1'b1);
            end else if (aborted && resp_cnt != n_issued) begin
                if (req_cnt != n_issued) chk("abort_din_held", {din_valid, pcpi_wait}, 2'b11);
                else                     chk("drain", {pcpi_wait, dout_ready}, 2'b01);
            end
            if ((aborted || n_rdy > 0) && resp_cnt == n_issued) done = 1'b1;
        end
        chk("no_timeout", done, 1'b1);
        repeat (2) begin
            @(posedge clock); #1;
            chk("ready_single", pcpi_ready, 1'b0);
        end
        chk("ready_count", n_rdy, aborted ? 0 : 1);
        chk("din_once", req_cnt, n_issued);
        chk("din_rs1", cap_rs1, a);
        chk("din_rs2", cap_rs2, b);
        chk("din_bits", cap_bits, {insn[3], insn[13], insn[14], insn[30]});
    endtask

    task automatic no_match(input logic [31:0] insn, input int cycles);
        pcpi_insn  = insn;
        pcpi_valid = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); #1;
            chk("nomatch_quiet", {pcpi_wait, din_valid, pcpi_ready}, 3'b000);
        end
        pcpi_valid = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic run32(input string tag, input logic [31:0] insn, input logic [31:0] a,
                         input logic [31:0] b, input bit match, input logic [31:0] exp_rd);
        int n_rdy;
        n_rdy   = 0;
        insn_s  = insn;
        rs1_s   = a;
        rs2_s   = b;
        valid_s = 1'b1;
        @(posedge clock); #1;
        chk({tag, "_wait_t1"}, wait_s, match);
        for (int i = 0; i < 8; i++) begin
            if (ready_s) begin
                n_rdy++;
                chk({tag, "_rd"}, rd_s, exp_rd);
                valid_s = 1'b0;
            end else if (!match) begin
                chk({tag, "_quiet"}, {wait_s, din_valid_s}, 2'b00);
            end
            @(posedge clock); #1;
        end
        valid_s = 1'b0;
        chk({tag, "_nready"}, n_rdy, match);
        @(posedge clock); #1;
    endtask

    initial begin
        logic [31:0] insn;
        logic [31:0] nm_list [4];
        logic [63:0] a, b;
        int op, abort_at;

        nm_list[0] = 32'h00B50533;
        nm_list[1] = 32'h00006033;
        nm_list[2] = 32'h68001033;
        nm_list[3] = 32'h48006013;
        pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
        valid_s = 1'b0; insn_s = '0; rs1_s = '0; rs2_s = '0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_ctrl", {pcpi_wait, pcpi_ready, pcpi_wr, din_valid, dout_ready}, 5'b0);
        chk("rst_rd", pcpi_rd, 64'h0);
        chk("rst_din", {din_rs1, din_rs2, din_insn3, din_insn13, din_insn14, din_insn30}, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // bext, unit always ready
        begin_req(BEXT, 64'h12345678, 64'h0000FF00);
        end_req(BEXT, 64'h12345678, 64'h0000FF00, -1);
        chk("bext_plan", pcpi_rd, 64'h56);

        // bdep with din_ready held low: request must stay put on din
        hold_low_until = cyc + 1000;
        @(posedge clock); #1;
        begin_req(BDEP, 64'hAB, 64'hF0F0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", din_valid, 1'b1);
            chk("stall_ops", {din_rs1, din_rs2}, {64'hAB, 64'hF0F0});
            chk("stall_bits", {din_insn3, din_insn13, din_insn14, din_insn30}, 4'b0111);
            @(posedge clock); #1;
        end
        hold_low_until = 0;
        end_req(BDEP, 64'hAB, 64'hF0F0, -1);
        chk("bdep_plan", pcpi_rd, 64'hA0B0);

        no_match(32'h00B50533, 20);

        // abort during WAIT, then a normal request
        begin_req(BEXT, 64'hDEADBEEF0F0F0F0F, 64'h00FF00FFF0F0F0F0);
        end_req(BEXT, 64'hDEADBEEF0F0F0F0F, 64'h00FF00FFF0F0F0F0, 1);
        chk("abort_rd_kept", pcpi_rd, 64'hA0B0);
        begin_req(BEXT | 32'h8, 64'hCAFEF00D, 64'h0F0F0F0F);
        end_req(BEXT | 32'h8, 64'hCAFEF00D, 64'h0F0F0F0F, -1);

        // reset while a request sits in ISSUE
        hold_low_until = cyc + 1000;
        @(posedge clock); #1;
        begin_req(GREVP, 64'h0123456789ABCDEF, 64'h3F);
        chk("pre_rst_issue", din_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_ctrl", {pcpi_wait, pcpi_ready, din_valid, dout_ready}, 4'b0);
        chk("async_rst_rd", pcpi_rd, 64'h0);
        chk("async_rst_din", {din_rs1, din_rs2, din_insn3, din_insn13, din_insn14, din_insn30}, 0);
        pcpi_valid = 1'b0;
        hold_low_until = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        begin_req(GREVP, 64'h0123456789ABCDEF, 64'h3F);
        end_req(GREVP, 64'h0123456789ABCDEF, 64'h3F, -1);
        chk("grev_rev64", pcpi_rd, 64'hF7B3D591E6A2C480);

        // RV32 instance without grev
        run32("s_bext", BEXT, 32'h12345678, 32'h0000FF00, 1'b1, 32'h56);
        run32("s_grev", GREVP, 32'h12345678, 32'h1F, 1'b0, 32'h0);
        run32("s_bextw", BEXT | 32'h8, 32'h12345678, 32'hFF, 1'b0, 32'h0);
        run32("s_bdep", BDEP, 32'hAB, 32'hF0F0, 1'b1, 32'hA0B0);

        // randomized traffic with unit stalls and occasional aborts
        stall_mode = 1'b1;
        for (int r = 0; r < 1000; r++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
            if ($urandom_range(0, 19) == 0) begin
                no_match(nm_list[$urandom_range(0, 3)], 3);
            end else begin
                op   = int'($urandom_range(0, 2));
                insn = (op == 0) ? BEXT : (op == 1) ? BDEP : GREVP;
                insn = insn | ($urandom_range(0, 1) != 0 ? 32'h8 : 32'h0) | ($urandom & ~MASK);
                a    = {$urandom, $urandom};
                b    = (op == 2) ? 64'($urandom_range(0, 63)) : {$urandom, $urandom};
                abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
                begin_req(insn, a, b);
                end_req(insn, a, b, abort_at);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
